otp_ecc_reg_array: RTL

- Parametrised successor to the single-value ECC register block: a Depth x Width register array protected by extended-Hamming SECDED.
- One host write port and one host read port with 1-cycle read latency.
- A background scrub engine sweeps all entries, corrects single-bit errors in place and flags uncorrectable entries.
- Sits beside the OTP controller partition logic as its shadow storage.

---
 rtl/otp_ecc_reg_array.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/otp_ecc_reg_array.sv
// Depth x Width register array protected by extended-Hamming SECDED, with a
// 1-cycle host read port, a host write port and a background scrub engine.
module otp_ecc_reg_array #(
  parameter int Width = 32,
  parameter int Depth = 15,
  localparam int AddrW = $clog2(Depth),
  localparam int ParW  = (Width <= 4)  ? 4 :
                         (Width <= 11) ? 5 :
                         (Width <= 26) ? 6 :
                         (Width <= 57) ? 7 : 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wr_en_i,
  input  logic [AddrW-1:0]      wr_addr_i,
  input  logic [Width-1:0]      wr_data_i,
  input  logic [Width+ParW-1:0] wr_flip_i,
  input  logic                  rd_en_i,
  input  logic [AddrW-1:0]      rd_addr_i,
  output logic                  rd_valid_o,
  output logic [Width-1:0]      rd_data_o,
  output logic [1:0]            rd_err_o,
  input  logic                  scrub_req_i,
  output logic                  scrub_busy_o,
  output logic                  scrub_done_o,
  output logic [7:0]            scrub_corr_cnt_o,
  output logic                  fatal_o,
  output logic [31:0]           addr_w_o
);

  localparam int PB = ParW - 1;
  localparam int HW = Width + PB;
  localparam int CW = Width + ParW;
  localparam logic [AddrW:0]   DepthA  = (AddrW + 1)'(Depth);
  localparam logic [AddrW-1:0] LastPtr = AddrW'(Depth - 1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  // Data fills the non-power-of-two positions; parity bits zero the syndrome.
  function automatic logic [CW-1:0] encode(input logic [Width-1:0] d);
    logic [CW-1:0] cw;
    logic [PB-1:0] syn;
    int k;
    cw  = '0;
    syn = '0;
    k   = 0;
    for (int i = 0; i < HW; i++) begin
      if (((i + 1) & i) != 0) begin
        cw[i] = d[k];
        k++;
      end else begin
        cw[i] = 1'b0;
      end
    end
    for (int i = 0; i < HW; i++) begin
      if (cw[i]) syn = syn ^ PB'(i + 1);
      else       syn = syn;
    end
    for (int j = 0; j < PB; j++) cw[(1 << j) - 1] = syn[j];
    cw[CW-1] = ^cw[HW-1:0];
    return cw;
  endfunction

  // Returns {status, data}; uncorrectable words keep their raw data bits.
  function automatic logic [Width+1:0] decode(input logic [CW-1:0] cw);
    logic [CW-1:0]    fx;
    logic [PB-1:0]    syn;
    logic [Width-1:0] d;
    logic [1:0]       err;
    int k;
    syn = '0;
    for (int i = 0; i < HW; i++) begin
      if (cw[i]) syn = syn ^ PB'(i + 1);
      else       syn = syn;
    end
    fx = cw;
    if (^cw) begin
      err = 2'b01;
      if (syn == '0)               fx[CW-1] = ~fx[CW-1];
      else if (int'(syn) <= HW)    fx[int'(syn) - 1] = ~fx[int'(syn) - 1];
      else                         fx = cw;
    end else if (syn != '0) begin
      err = 2'b10;
    end else begin
      err = 2'b00;
    end
    d = '0;
    k = 0;
    for (int i = 0; i < HW; i++) begin
      if (((i + 1) & i) != 0) begin
        d[k] = fx[i];
        k++;
      end else begin
        k = k;
      end
    end
    return {err, d};
  endfunction

  logic [CW-1:0]      mem_q [Depth];
  logic [CW-1:0]      mem_d [Depth];
  state_e             state_q, state_d;
  logic [AddrW-1:0]   ptr_q, ptr_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [7:0]         corr_cnt_q, corr_cnt_d;
  logic               fatal_q, fatal_d;
  logic               rd_valid_q, rd_valid_d;
  logic [Width-1:0]   rd_data_q, rd_data_d;
  logic [1:0]         rd_err_q, rd_err_d;

  logic               rd_in_range_s, wr_in_range_s, host_busy_s;
  logic [CW-1:0]      rd_cw_s;
  logic [Width+1:0]   rd_dec_s, scan_dec_s;

  // Address checks and the two combinational decoders.
  always_comb begin
    rd_in_range_s = ({1'b0, rd_addr_i} < DepthA);
    wr_in_range_s = ({1'b0, wr_addr_i} < DepthA);
    host_busy_s   = wr_en_i | rd_en_i;
    if (rd_in_range_s) rd_cw_s = mem_q[rd_addr_i];
    else               rd_cw_s = '0;
    rd_dec_s   = decode(rd_cw_s);
    scan_dec_s = decode(mem_q[ptr_q]);
  end

  // Host port, storage update and scrub next-state logic.
  always_comb begin
    mem_d      = mem_q;
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    corr_cnt_d = corr_cnt_q;
    fatal_d    = fatal_q;
    rd_valid_d = rd_en_i;
    rd_data_d  = rd_data_q;
    rd_err_d   = rd_err_q;

    if (rd_en_i && rd_in_range_s) begin
      rd_data_d = rd_dec_s[Width-1:0];
      rd_err_d  = rd_dec_s[Width+1:Width];
      if (rd_dec_s[Width+1:Width] == 2'b10) fatal_d = 1'b1;
      else                                  fatal_d = fatal_q;
    end else if (rd_en_i) begin
      rd_data_d = '0;
      rd_err_d  = 2'b11;
    end else begin
      rd_data_d = rd_data_q;
    end

    if (wr_en_i && wr_in_range_s) mem_d[wr_addr_i] = encode(wr_data_i) ^ wr_flip_i;
    else                          mem_d = mem_d;

    // Host traffic in any cycle freezes the sweep; the host always wins.
    case (state_q)
      IDLE: begin
        if (scrub_req_i) begin
          state_d = SCAN;
          ptr_d   = '0;
          cnt_d   = 8'd0;
        end else begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (!host_busy_s) begin
          if (scan_dec_s[Width+1:Width] == 2'b01) begin
            mem_d[ptr_q] = encode(scan_dec_s[Width-1:0]);
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
            else                cnt_d = cnt_q;
          end else if (scan_dec_s[Width+1:Width] == 2'b10) begin
            fatal_d = 1'b1;
          end else begin
            cnt_d = cnt_q;
          end
          if (ptr_q == LastPtr) begin
            state_d    = DONE;
            corr_cnt_d = cnt_d;
          end else begin
            ptr_d = ptr_q + AddrW'(1);
          end
        end else begin
          ptr_d = ptr_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset clears every entry to the all-zero-data codeword.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= encode('0);
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= 8'd0;
      corr_cnt_q <= 8'd0;
      fatal_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 2'b00;
    end else begin
      mem_q      <= mem_d;
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      corr_cnt_q <= corr_cnt_d;
      fatal_q    <= fatal_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      rd_err_q   <= rd_err_d;
    end
  end

  assign rd_valid_o       = rd_valid_q;
  assign rd_data_o        = rd_data_q;
  assign rd_err_o         = rd_err_q;
  assign scrub_busy_o     = (state_q != IDLE);
  assign scrub_done_o     = (state_q == DONE);
  assign scrub_corr_cnt_o = corr_cnt_q;
  assign fatal_o          = fatal_q;
  assign addr_w_o         = 32'(AddrW);

endmodule
